// File: rtl/pipe_adder_pkg.sv
// Shared constants and operation encoding for the chunked pipelined adder.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice with carry-in and carry-out.
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Carry-chained add/sub pipeline: each stage adds one CW-bit chunk and hands the
// rest of its beat (remaining operand chunks, finished sum chunks) to the next.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  b_eff;
  alu_op_e           op;

  assign op    = alu_op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~in2 : in2;

  // Advance resolves from the output back so a bubble anywhere lets upstream move.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = valid_q[STAGES-1] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~valid_q[0] | adv[0];

  always_comb begin
    load = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all stages update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k])     valid_q[k] <= 1'b1;
        else if (adv[k]) valid_q[k] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RIN = WIDTH - k * CW;  // operand bits not yet added
    localparam int SW  = (k + 1) * CW;    // sum bits complete after this stage

    logic [RIN-1:0] a_in;
    logic [RIN-1:0] b_in;
    logic           c_in;
    logic [CW-1:0]  s_chunk;
    logic           c_out;
    logic [SW-1:0]  s_new;
    logic [SW-1:0]  s_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign a_in  = in1;
      assign b_in  = b_eff;
      assign c_in  = sub;
      assign s_new = s_chunk;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_hold.a_q;
      assign b_in  = g_stage[k-1].g_hold.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign s_new = {s_chunk, g_stage[k-1].s_q};
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a    (a_in[CW-1:0]),
      .b    (b_in[CW-1:0]),
      .cin  (c_in),
      .sum  (s_chunk),
      .cout (c_out)
    );

    // NOTE: data registers get a reset too, so outputs never show X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (load[k]) begin
        s_q <= s_new;
        c_q <= c_out;
      end
    end

    if (k < STAGES - 1) begin : g_hold
      logic [RIN-CW-1:0] a_q;
      logic [RIN-CW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k]) begin
          a_q <= a_in[RIN-1:CW];
          b_q <= b_in[RIN-1:CW];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Carry into the MSB is recovered as sum ^ a ^ b at the top bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load[k]) begin
          ovf_q <= s_chunk[CW-1] ^ a_in[RIN-1] ^ b_in[RIN-1] ^ c_out;
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out       = g_stage[STAGES-1].s_q;
  assign carry     = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
  // Qualified with valid so the flag reads 0 out of reset like the other outputs.
  assign zero      = valid_q[STAGES-1] & (out == '0);

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; 1 <= STAGES <= WIDTH; chunk width CW = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry  output  1  carry-out of MSB (for sub: 1 = no borrow, A >= B unsigned).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  out == 0.

Function
REQ-016 Sub SHALL be performed as A + ~B + 1; carry-in of chunk 0 = sub.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k (bits k*CW+CW-1 : k*CW) of A and effective B plus the carry registered from stage k-1, registering partial sum and carry-out.
REQ-018 Unprocessed operand chunks and completed sum chunks SHALL travel with their beat so each beat's result is independent of neighbouring beats.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, absent backpressure.
REQ-020 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-021 Each stage holds valid_k; stage k advances when valid_k and (stage k+1 empty or advancing); last stage advances when out_ready.
REQ-022 in_ready SHALL equal !valid_0 | stage 0 advancing (combinational, no dependency on in_valid).
REQ-023 out_valid, out, carry, overflow, zero SHALL be driven from last-stage registers; stable while out_valid & !out_ready.
REQ-024 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-025 zero SHALL be computed from the registered final sum, not pipelined separately.
REQ-026 Bubbles SHALL collapse: an empty stage accepts from upstream even when downstream is stalled.
REQ-027 Simultaneous accept at input and release at output when full SHALL lose and duplicate no beat.
REQ-028 in_valid while !in_ready: beat SHALL NOT be captured; sender holds it.
REQ-029 STAGES = 1 SHALL degenerate to a single registered adder with identical handshake.

Reset
REQ-030 rst_n low SHALL asynchronously clear all valid_k; out_valid = 0, in_ready = 1 while held low.
REQ-031 out, carry, overflow, zero SHALL reset to 0; data registers SHALL reset to 0.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; first beat after deassertion emerges after STAGES cycles.

Structure
REQ-033 Shared package SHALL hold default WIDTH/STAGES constants and the ALU op encoding ADD=0, SUB=1.
REQ-034 One sub-module, adder_chunk (CW-bit add with carry-in/carry-out, combinational), instantiated once per stage via generate.

Verification
REQ-035 WIDTH=32, STAGES=4: in1=0x0000_0005, in2=0x0000_0003, sub=0 -> out=0x0000_0008, carry=0, overflow=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-036 in1=0x7FFF_FFFF, in2=0x0000_0001, sub=0 -> out=0x8000_0000, overflow=1, carry=0; in1=0xFFFF_FFFF, in2=1 -> out=0, carry=1, zero=1, overflow=0.
REQ-037 sub=1, in1=3, in2=5 -> out=0xFFFF_FFFE, carry=0; in1=0x8000_0000, in2=1 -> out=0x7FFF_FFFF, overflow=1, carry=1.
REQ-038 Stream 16 random beats with out_ready held low 10 cycles: in_ready falls after 4 accepted; all 16 results in order, none lost or duplicated.
REQ-039 Assert rst_n low with 3 beats in flight -> out_valid drops immediately; after release, beat 0xA+0xB emerges as 0x15 after 4 cycles, no stale output.
REQ-040 Repeat REQ-035..REQ-038 with STAGES=1 and WIDTH=8, STAGES=2: 8'h7F+8'h01 -> 8'h80, overflow=1.
